// File: rtl/sram_mem_controller.sv
// MEM-stage data memory controller: sequences each 32-bit load/store as two
// 16-bit SRAM transfers with programmable wait states, holding ready low meanwhile.
module sram_mem_controller #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_BASE   = 1024,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdEn,
    input  logic                   wrEn,
    input  logic [31:0]            address,
    input  logic [31:0]            writeData,
    output logic [31:0]            readData,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sramAddr,
    output logic [15:0]            sramDataOut,
    output logic                   sramDataOE,
    input  logic [15:0]            sramDataIn,
    output logic                   sramWeN,
    output logic                   sramOeN
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SRAM_ADDR_W-2:0]   addr_q, addr_d;
    logic [31:0]              data_q, data_d;
    logic                     wr_q, wr_d;
    logic [31:0]              rdata_q, rdata_d;

    logic [31:0]              offset;
    logic [SRAM_ADDR_W-2:0]   word_addr;
    logic                     cnt_last;
    logic                     hi_phase;
    logic                     unused_offset_bits;

    // Offset wraps modulo the SRAM size; byte-lane bits are ignored.
    assign offset             = address - 32'(ADDR_BASE);
    assign word_addr          = offset[SRAM_ADDR_W:2];
    assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};
    assign cnt_last           = (cnt_q == CNT_LAST);
    assign hi_phase           = (state_q == HIGH);
    assign readData           = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wr_d        = wr_q;
        rdata_d     = rdata_q;
        ready       = 1'b0;
        sramAddr    = '0;
        sramDataOut = '0;
        sramDataOE  = 1'b0;
        sramWeN     = 1'b1;
        sramOeN     = 1'b1;

        unique case (state_q)
            IDLE: begin
                ready = ~(rdEn | wrEn);
                if (rdEn | wrEn) begin
                    addr_d  = word_addr;
                    data_d  = writeData;
                    wr_d    = wrEn;
                    cnt_d   = '0;
                    state_d = LOW;
                end
            end
            LOW, HIGH: begin
                sramAddr = {addr_q, hi_phase};
                if (wr_q) begin
                    sramWeN     = 1'b0;
                    sramDataOE  = 1'b1;
                    sramDataOut = hi_phase ? data_q[31:16] : data_q[15:0];
                end else begin
                    sramOeN = 1'b0;
                end
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = hi_phase ? DONE : HIGH;
                    // Capture on the last wait cycle, when SRAM data has settled.
                    if (!wr_q) begin
                        if (hi_phase) rdata_d[31:16] = sramDataIn;
                        else          rdata_d[15:0]  = sramDataIn;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench: default-parameter controller plus a WAIT_CYCLES=0 instance,
// each with a small behavioural SRAM model.
module tb_sram_mem_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Default instance signals
    logic        rd_a, wr_a, ready_a, oe_a, wen_a, oen_a;
    logic [31:0] addr_a, wd_a, rdata_a;
    logic [17:0] saddr_a;
    logic [15:0] sout_a, sin_a;
    // WAIT_CYCLES=0 instance signals
    logic        rd_b, wr_b, ready_b, oe_b, wen_b, oen_b;
    logic [31:0] addr_b, wd_b, rdata_b;
    logic [17:0] saddr_b;
    logic [15:0] sout_b, sin_b;

    sram_mem_controller dut (
        .clk(clk), .rst(rst), .rdEn(rd_a), .wrEn(wr_a), .address(addr_a),
        .writeData(wd_a), .readData(rdata_a), .ready(ready_a), .sramAddr(saddr_a),
        .sramDataOut(sout_a), .sramDataOE(oe_a), .sramDataIn(sin_a),
        .sramWeN(wen_a), .sramOeN(oen_a)
    );

    sram_mem_controller #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .rdEn(rd_b), .wrEn(wr_b), .address(addr_b),
        .writeData(wd_b), .readData(rdata_b), .ready(ready_b), .sramAddr(saddr_b),
        .sramDataOut(sout_b), .sramDataOE(oe_b), .sramDataIn(sin_b),
        .sramWeN(wen_b), .sramOeN(oen_b)
    );

    // SRAM models: unwritten locations return a fixed preload pattern.
    logic [15:0] mem_a [16];
    logic        val_a [16];
    logic [15:0] mem_b [16];
    logic        val_b [16];

    function automatic logic [15:0] preload(input logic [3:0] a);
        if (a == 4'd2) return 16'hBEEF;
        if (a == 4'd3) return 16'hCAFE;
        return 16'h0000;
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) begin
                val_a[i] <= 1'b0;
                val_b[i] <= 1'b0;
            end
        end else begin
            if (!wen_a) begin
                mem_a[saddr_a[3:0]] <= sout_a;
                val_a[saddr_a[3:0]] <= 1'b1;
            end
            if (!wen_b) begin
                mem_b[saddr_b[3:0]] <= sout_b;
                val_b[saddr_b[3:0]] <= 1'b1;
            end
        end
    end

    assign sin_a = val_a[saddr_a[3:0]] ? mem_a[saddr_a[3:0]] : preload(saddr_a[3:0]);
    assign sin_b = val_b[saddr_b[3:0]] ? mem_b[saddr_b[3:0]] : preload(saddr_b[3:0]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the default instance starting in IDLE (cycle 0);
    // request held only for cycle 0, so it is dropped during LOW.
    task automatic run_a(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [17:0] exp_base,
                         input logic [31:0] exp_rdata);
        rd_a = rd; wr_a = wr; addr_a = a; wd_a = d;
        #0;
        check("req_ready_low", {31'b0, ready_a}, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) begin
                rd_a = 1'b0; wr_a = 1'b0;
            end
            if (c <= 4) begin
                check($sformatf("c%0d_ready", c), {31'b0, ready_a}, 32'd0);
                check($sformatf("c%0d_addr", c), {14'b0, saddr_a},
                      {14'b0, exp_base + ((c >= 3) ? 18'd1 : 18'd0)});
                if (wr) begin
                    check($sformatf("c%0d_wen", c), {31'b0, wen_a}, 32'd0);
                    check($sformatf("c%0d_oe", c), {31'b0, oe_a}, 32'd1);
                    check($sformatf("c%0d_dout", c), {16'b0, sout_a},
                          {16'b0, (c >= 3) ? d[31:16] : d[15:0]});
                end else begin
                    check($sformatf("c%0d_oen", c), {31'b0, oen_a}, 32'd0);
                    check($sformatf("c%0d_wen_idle", c), {31'b0, wen_a}, 32'd1);
                end
            end else begin
                check("done_ready", {31'b0, ready_a}, 32'd1);
                check("done_wen", {31'b0, wen_a}, 32'd1);
                check("done_oen", {31'b0, oen_a}, 32'd1);
                check("done_rdata", rdata_a, exp_rdata);
            end
        end
        step();
        check("post_idle_ready", {31'b0, ready_a}, 32'd1);
        check("post_rdata_held", rdata_a, exp_rdata);
        $display("txn a: rd=%0b wr=%0b addr=%0d wdata=%h rdata=%h", rd, wr, a, d, rdata_a);
    endtask

    initial begin
        rd_a = 0; wr_a = 0; addr_a = 0; wd_a = 0;
        rd_b = 0; wr_b = 0; addr_b = 0; wd_b = 0;
        step(); step();
        mem_clr = 1'b0;
        rst = 1'b0;
        step();

        // Idle after reset
        check("rst_ready", {31'b0, ready_a}, 32'd1);
        check("rst_wen", {31'b0, wen_a}, 32'd1);
        check("rst_oen", {31'b0, oen_a}, 32'd1);
        check("rst_oe", {31'b0, oe_a}, 32'd0);
        check("rst_rdata", rdata_a, 32'd0);
        check("rst_saddr", {14'b0, saddr_a}, 32'd0);
        check("rst_ready0", {31'b0, ready_b}, 32'd1);
        $display("txn a: reset idle ready=%0b rdata=%h", ready_a, rdata_a);

        // Store, load, simultaneous rd+wr, load back of that write
        run_a(1'b0, 1'b1, 32'd1024, 32'h12345678, 18'd0, 32'h0);
        run_a(1'b1, 1'b0, 32'd1028, 32'h0, 18'd2, 32'hCAFEBEEF);
        run_a(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 18'd4, 32'hCAFEBEEF);
        run_a(1'b1, 1'b0, 32'd1035, 32'h0, 18'd4, 32'hA5A55A5A);
        run_a(1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 32'h12345678);

        // Asynchronous reset during HIGH of a store
        rd_a = 0; wr_a = 1; addr_a = 32'd1036; wd_a = 32'h0BADF00D;
        step(); wr_a = 0;
        step(); step();
        check("rhigh_wen", {31'b0, wen_a}, 32'd0);
        check("rhigh_addr", {14'b0, saddr_a}, 32'd7);
        #2 rst = 1'b1;
        #1;
        check("arst_wen", {31'b0, wen_a}, 32'd1);
        check("arst_oe", {31'b0, oe_a}, 32'd0);
        check("arst_ready", {31'b0, ready_a}, 32'd1);
        check("arst_rdata", rdata_a, 32'd0);
        check("arst_saddr", {14'b0, saddr_a}, 32'd0);
        $display("txn a: async reset mid-store wen=%0b rdata=%h", wen_a, rdata_a);
        step();
        rst = 1'b0;
        step();
        run_a(1'b1, 1'b0, 32'd1028, 32'h0, 18'd2, 32'hCAFEBEEF);

        // WAIT_CYCLES=0: back-to-back store then load at the same address
        wr_b = 1; addr_b = 32'd1024; wd_b = 32'h11223344;
        #0;
        check("w0_req_ready", {31'b0, ready_b}, 32'd0);
        step(); wr_b = 0;
        check("w0_c1_wen", {31'b0, wen_b}, 32'd0);
        check("w0_c1_addr", {14'b0, saddr_b}, 32'd0);
        check("w0_c1_dout", {16'b0, sout_b}, 32'h3344);
        step();
        check("w0_c2_addr", {14'b0, saddr_b}, 32'd1);
        check("w0_c2_dout", {16'b0, sout_b}, 32'h1122);
        step();
        check("w0_c3_ready", {31'b0, ready_b}, 32'd1);
        step();
        rd_b = 1;
        #0;
        check("w0_c4_ready", {31'b0, ready_b}, 32'd0);
        step(); rd_b = 0;
        check("w0_c5_oen", {31'b0, oen_b}, 32'd0);
        check("w0_c5_ready", {31'b0, ready_b}, 32'd0);
        step();
        check("w0_c6_addr", {14'b0, saddr_b}, 32'd1);
        step();
        check("w0_c7_ready", {31'b0, ready_b}, 32'd1);
        check("w0_c7_rdata", rdata_b, 32'h11223344);
        $display("txn b: wait0 store/load rdata=%h", rdata_b);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
Multi-cycle controller between the MEM pipeline stage and a 16-bit-wide external SRAM. It replaces the single-cycle data memory in the MEM stage. Each 32-bit load or store is sequenced as two half-word SRAM transfers with programmable wait states. While a transfer is in flight, `ready` is held low so the top level can freeze every pipeline register.

Parameters:
- WAIT_CYCLES, 1, extra cycles per half-word phase; each phase lasts WAIT_CYCLES+1 cycles.
- ADDR_BASE, 1024, byte address mapped to SRAM word 0; subtracted before mapping.
- SRAM_ADDR_W, 18, SRAM half-word address width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- rdEn  input  1  MEM-stage load request (memRead).
- wrEn  input  1  MEM-stage store request (memWrite).
- address  input  32  byte address (ALU result).
- writeData  input  32  store data (reg2Val).
- readData  output  32  load result; valid in DONE and held afterwards.
- ready  output  1  1 = no transfer pending; 0 = freeze the pipeline.
- sramAddr  output  SRAM_ADDR_W  SRAM half-word address.
- sramDataOut  output  16  data driven to SRAM.
- sramDataOE  output  1  1 = drive sramDataOut onto the SRAM bus.
- sramDataIn  input  16  data returned from SRAM.
- sramWeN  output  1  SRAM write enable, active-low.
- sramOeN  output  1  SRAM output enable, active-low.

Behaviour:
- Reset is asynchronous and active-high. Regardless of clk it forces:
  - state to IDLE and the wait counter to 0;
  - readData=0, latched address/data/op=0;
  - sramWeN=1, sramOeN=1, sramDataOE=0, sramAddr=0, sramDataOut=0.
  Reset mid-transaction abandons that transaction; no SRAM strobe remains asserted.
- Address map:
  - wordAddr = (address − ADDR_BASE) >> 2, truncated to SRAM_ADDR_W−1 bits; wraps modulo, with no range check.
  - Low half-word is at {wordAddr,0}; high half-word is at {wordAddr,1}.
  - address[1:0] is ignored.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - ready = ~(rdEn|wrEn), combinational.
  - On a request: latch wordAddr, writeData and op, then go to LOW with counter=0. Write takes priority when rdEn and wrEn are both 1, and readData is then unchanged.
  - All SRAM strobes are inactive.
- LOW:
  - ready=0; sramAddr={wordAddr,0}.
  - Write: sramWeN=0, sramDataOE=1, sramDataOut=data[15:0].
  - Read: sramOeN=0; readData[15:0] is captured from sramDataIn on the clock edge where counter==WAIT_CYCLES.
  - The counter increments each cycle. When counter==WAIT_CYCLES, go to HIGH with counter=0.
- HIGH: same as LOW, with address {wordAddr,1}, data[31:16] and readData[31:16]. When counter==WAIT_CYCLES, go to DONE.
- DONE:
  - ready=1 for exactly one cycle; the pipeline advances on this edge.
  - All strobes are inactive; readData holds the full word.
  - Always return to IDLE, even if a request is still high. The next request is evaluated in IDLE.
- Request inputs are don't-care outside IDLE. The latched copy is used, so a request dropping mid-transfer still completes.
- Latency: the request is seen in IDLE at cycle 0, and ready=1 in cycle 1+2·(WAIT_CYCLES+1). That is cycle 5 for the default, and cycle 3 for WAIT_CYCLES=0.
- Throughput: back-to-back requests cost 2·(WAIT_CYCLES+1)+2 cycles each.
- SRAM outputs are combinational from the state and latched registers. They are glitch-tolerant by design: sramWeN is deasserted in IDLE and DONE.
- readData changes only on capture edges or reset.

Test Plan:
- Idle, no request: rst pulse, then rdEn=wrEn=0 → ready=1, sramWeN=1, sramOeN=1, sramDataOE=0, readData=0.
- Store, default parameters: wrEn=1, address=1024, writeData=0x12345678 → expected response:
  - cycles 1-2: sramAddr=0, sramDataOut=0x5678, sramWeN=0;
  - cycles 3-4: sramAddr=1, sramDataOut=0x1234;
  - cycle 5: ready=1.
- Load with SRAM model: rdEn=1, address=1028, model holds 0xBEEF@2 and 0xCAFE@3 → sramOeN=0 in cycles 1-4, ready=1 in cycle 5, readData=0xCAFEBEEF.
- WAIT_CYCLES=0, back-to-back store then load at the same address → each completes in 3 cycles plus the IDLE cycle; load returns the stored word.
- Simultaneous rdEn=wrEn=1 → write sequence performed; readData unchanged. Request dropped during LOW → transaction still completes and ready pulses.
- Assert rst during HIGH of a store → sramWeN=1 immediately (before the next clk edge), state IDLE, readData=0; a subsequent load completes normally.
